// File: rtl/tpp_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tpp_frame_ctrl
//    Receive-side sequencer for the TPP decoder. Arms the decoder, waits for
//    the frame delimiter, packs 2-bit symbols (MSB first) into bytes, decodes
//    the command head and the length byte, counts payload bytes and reports
//    completion back to the decoder. Framing errors and inter-symbol gaps
//    longer than TIMEOUT cycles are latched for the command layer.
//
// Ports
//    dec_clk        decoder-domain clock, posedge
//    rst_n          asynchronous active-low reset
//    rx_arm         1-cycle request to start receiving a frame
//    delimiter_det  1-cycle pulse, delimiter found
//    sym_valid      1-cycle pulse, sym_data valid
//    sym_data[1:0]  TPP symbol, MSB-first within a byte
//    dec_done       decoder finished (level or pulse)
//    dec_en         decoder enable
//    cmd_head[7:0]  first byte of the frame
//    head_finish    head byte complete (held until IDLE)
//    cmd_end        frame complete (level while in DONE)
//    frame_byte     last assembled byte
//    byte_valid     1-cycle strobe, frame_byte updated
//    byte_idx[5:0]  index of frame_byte within the frame, saturates at 63
//    frame_err      error latched
//    err_code[1:0]  01 timeout, 10 length > MAX_LEN, 11 premature dec_done
// -----------------------------------------------------------------------------
module tpp_frame_ctrl #(
   parameter logic [7:0]  CODE_QUERYREP = 8'h01,
   parameter logic [7:0]  CODE_DISPERSE = 8'h02,
   parameter logic [7:0]  CODE_SHRINK   = 8'h03,
   parameter logic [7:0]  CODE_NAK      = 8'h04,
   parameter logic [7:0]  MAX_LEN       = 8'd16,
   parameter logic [15:0] TIMEOUT       = 16'd1200
) (
   input  logic       dec_clk,
   input  logic       rst_n,
   input  logic       rx_arm,
   input  logic       delimiter_det,
   input  logic       sym_valid,
   input  logic [1:0] sym_data,
   input  logic       dec_done,
   output logic       dec_en,
   output logic [7:0] cmd_head,
   output logic       head_finish,
   output logic       cmd_end,
   output logic [7:0] frame_byte,
   output logic       byte_valid,
   output logic [5:0] byte_idx,
   output logic       frame_err,
   output logic [1:0] err_code
);

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT_DELIM, S_HEAD, S_LEN, S_PAYLOAD, S_DONE, S_ERR
   } state_t;

   state_t      state_reg, state_next;
   logic [7:0]  shift_reg;
   logic [1:0]  sym_cnt_reg;
   logic [7:0]  len_reg;
   logic [7:0]  pay_cnt_reg;
   logic [15:0] gap_cnt_reg;

   logic        active;
   logic        arm_clear;
   logic        resync;
   logic        err_set;
   logic [1:0]  err_code_next;
   logic        is_short;
   logic [7:0]  pay_cnt_inc;

   always_ff @(posedge dec_clk or negedge rst_n) begin
      if (!rst_n) state_reg <= S_IDLE;
      else        state_reg <= state_next;
   end

   // Byte decisions are taken in the strobe cycle (byte_valid high), so the
   // resulting DONE state -- and cmd_end -- appear one cycle after the strobe.
   always_comb begin
      state_next    = state_reg;
      arm_clear     = 1'b0;
      resync        = 1'b0;
      err_set       = 1'b0;
      err_code_next = err_code;
      dec_en        = 1'b0;
      cmd_end       = 1'b0;
      active        = (state_reg == S_HEAD) || (state_reg == S_LEN) ||
                      (state_reg == S_PAYLOAD);
      is_short      = (frame_byte == CODE_QUERYREP) || (frame_byte == CODE_DISPERSE) ||
                      (frame_byte == CODE_SHRINK)   || (frame_byte == CODE_NAK);
      pay_cnt_inc   = pay_cnt_reg + 8'd1;

      case (state_reg)
         S_IDLE: begin
            if (rx_arm) begin
               state_next = S_WAIT_DELIM;
               arm_clear  = 1'b1;
            end
         end
         S_WAIT_DELIM: begin
            dec_en = 1'b1;
            if (delimiter_det) begin
               state_next = S_HEAD;
               resync     = 1'b1;
            end
         end
         S_HEAD, S_LEN, S_PAYLOAD: begin
            dec_en = 1'b1;
            // Priority: resync, premature finish, timeout, byte decision.
            if (delimiter_det) begin
               state_next = S_HEAD;
               resync     = 1'b1;
            end else if (dec_done) begin
               err_set       = 1'b1;
               err_code_next = 2'b11;
            end else if (!sym_valid && (gap_cnt_reg == TIMEOUT - 16'd1)) begin
               err_set       = 1'b1;
               err_code_next = 2'b01;
            end else if (byte_valid) begin
               if (state_reg == S_HEAD) begin
                  state_next = is_short ? S_DONE : S_LEN;
               end else if (state_reg == S_LEN) begin
                  if (frame_byte > MAX_LEN) begin
                     err_set       = 1'b1;
                     err_code_next = 2'b10;
                  end else if (frame_byte == 8'd0) begin
                     state_next = S_DONE;
                  end else begin
                     state_next = S_PAYLOAD;
                  end
               end else if (pay_cnt_inc == len_reg) begin
                  state_next = S_DONE;
               end
            end
            if (err_set) state_next = S_ERR;
         end
         S_DONE: begin
            dec_en  = 1'b1;
            cmd_end = 1'b1;
            if (dec_done) state_next = S_IDLE;
         end
         S_ERR: begin
            if (rx_arm) begin
               state_next = S_WAIT_DELIM;
               arm_clear  = 1'b1;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge dec_clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_head    <= 8'h00;
         head_finish <= 1'b0;
         frame_byte  <= 8'h00;
         byte_valid  <= 1'b0;
         byte_idx    <= 6'd0;
         frame_err   <= 1'b0;
         err_code    <= 2'b00;
         shift_reg   <= 8'h00;
         sym_cnt_reg <= 2'd0;
         len_reg     <= 8'h00;
         pay_cnt_reg <= 8'h00;
         gap_cnt_reg <= 16'd0;
      end else begin
         byte_valid <= 1'b0;
         if (arm_clear) begin
            frame_err   <= 1'b0;
            err_code    <= 2'b00;
            head_finish <= 1'b0;
            byte_idx    <= 6'd0;
            shift_reg   <= 8'h00;
            sym_cnt_reg <= 2'd0;
            len_reg     <= 8'h00;
            pay_cnt_reg <= 8'h00;
            gap_cnt_reg <= 16'd0;
         end else if (resync) begin
            // Partial byte is dropped silently; no strobe is generated.
            shift_reg   <= 8'h00;
            sym_cnt_reg <= 2'd0;
            pay_cnt_reg <= 8'h00;
            byte_idx    <= 6'd0;
            head_finish <= 1'b0;
            gap_cnt_reg <= 16'd0;
         end else if (active) begin
            if (err_set) begin
               // An error freezes the datapath; only the flags move.
               frame_err <= 1'b1;
               err_code  <= err_code_next;
            end else begin
               gap_cnt_reg <= sym_valid ? 16'd0 : gap_cnt_reg + 16'd1;
               if (sym_valid) begin
                  shift_reg   <= {shift_reg[5:0], sym_data};
                  sym_cnt_reg <= sym_cnt_reg + 2'd1;
                  if (sym_cnt_reg == 2'd3) begin
                     frame_byte <= {shift_reg[5:0], sym_data};
                     byte_valid <= 1'b1;
                  end
               end
               if (byte_valid) begin
                  if (byte_idx != 6'd63) byte_idx <= byte_idx + 6'd1;
                  case (state_reg)
                     S_HEAD: begin
                        cmd_head    <= frame_byte;
                        head_finish <= 1'b1;
                     end
                     S_LEN:     len_reg     <= frame_byte;
                     S_PAYLOAD: pay_cnt_reg <= pay_cnt_inc;
                     default:   ;
                  endcase
               end
            end
         end else if ((state_reg == S_DONE) && dec_done) begin
            head_finish <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_tpp_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tpp_frame_ctrl
//    Directed bench for tpp_frame_ctrl. Every expected byte strobe is pushed
//    into a scoreboard queue when its symbols are sent; a monitor pops and
//    compares on each byte_valid. Status outputs are checked inline.
//    Inputs are driven on the negedge; outputs are sampled on the negedge.
// -----------------------------------------------------------------------------
module tb_tpp_frame_ctrl;

   logic       dec_clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx_arm = 1'b0;
   logic       delimiter_det = 1'b0;
   logic       sym_valid = 1'b0;
   logic [1:0] sym_data = 2'b00;
   logic       dec_done = 1'b0;
   logic       dec_en;
   logic [7:0] cmd_head;
   logic       head_finish;
   logic       cmd_end;
   logic [7:0] frame_byte;
   logic       byte_valid;
   logic [5:0] byte_idx;
   logic       frame_err;
   logic [1:0] err_code;

   int n_checks = 0;
   int n_pass   = 0;
   logic [13:0] sb_q[$];   // {expected byte, expected index}

   always #5 dec_clk = ~dec_clk;

   tpp_frame_ctrl dut (
      .dec_clk       (dec_clk),
      .rst_n         (rst_n),
      .rx_arm        (rx_arm),
      .delimiter_det (delimiter_det),
      .sym_valid     (sym_valid),
      .sym_data      (sym_data),
      .dec_done      (dec_done),
      .dec_en        (dec_en),
      .cmd_head      (cmd_head),
      .head_finish   (head_finish),
      .cmd_end       (cmd_end),
      .frame_byte    (frame_byte),
      .byte_valid    (byte_valid),
      .byte_idx      (byte_idx),
      .frame_err     (frame_err),
      .err_code      (err_code)
   );

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
         $display("check %s: got %0h (ok)", name, act);
      end else begin
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor
   always @(negedge dec_clk) begin
      if (rst_n && byte_valid) begin
         if (sb_q.size() == 0) begin
            check("unexpected_strobe", {8'h00, frame_byte}, 16'hFFFF);
         end else begin
            logic [13:0] e;
            e = sb_q.pop_front();
            check("strobe_byte", {8'h00, frame_byte}, {8'h00, e[13:6]});
            check("strobe_idx",  {10'd0, byte_idx},   {10'd0, e[5:0]});
         end
      end
   end

   // All stimulus tasks start and end just after a negedge.
   task automatic pulse_arm();
      rx_arm = 1'b1; @(negedge dec_clk); rx_arm = 1'b0;
   endtask
   task automatic pulse_delim();
      delimiter_det = 1'b1; @(negedge dec_clk); delimiter_det = 1'b0;
   endtask
   task automatic pulse_done();
      dec_done = 1'b1; @(negedge dec_clk); dec_done = 1'b0;
   endtask
   task automatic send_sym(input logic [1:0] d);
      sym_valid = 1'b1; sym_data = d; @(negedge dec_clk); sym_valid = 1'b0;
   endtask
   task automatic send_byte(input logic [7:0] b, input bit expect_strobe, input logic [5:0] idx);
      if (expect_strobe) sb_q.push_back({b, idx});
      send_sym(b[7:6]); send_sym(b[5:4]); send_sym(b[3:2]); send_sym(b[1:0]);
   endtask
   // After the last byte: cmd_end low in the strobe cycle, high one cycle later.
   task automatic expect_end(input string name);
      check({name, "_cmd_end_strobe_cycle"}, {15'd0, cmd_end}, 16'd0);
      @(negedge dec_clk);
      check({name, "_cmd_end"}, {15'd0, cmd_end}, 16'd1);
   endtask

   initial begin
      // ---- reset values
      repeat (2) @(negedge dec_clk);
      check("rst_dec_en",      {15'd0, dec_en},      16'd0);
      check("rst_cmd_head",    {8'd0, cmd_head},     16'h00);
      check("rst_head_finish", {15'd0, head_finish}, 16'd0);
      check("rst_cmd_end",     {15'd0, cmd_end},     16'd0);
      check("rst_frame_byte",  {8'd0, frame_byte},   16'h00);
      check("rst_byte_valid",  {15'd0, byte_valid},  16'd0);
      check("rst_byte_idx",    {10'd0, byte_idx},    16'd0);
      check("rst_frame_err",   {15'd0, frame_err},   16'd0);
      check("rst_err_code",    {14'd0, err_code},    16'd0);
      rst_n = 1'b1;
      @(negedge dec_clk);

      // ---- short command 0x01
      pulse_arm();
      check("short_dec_en_armed", {15'd0, dec_en}, 16'd1);
      pulse_delim();
      send_byte(8'h01, 1'b1, 6'd0);
      expect_end("short");
      check("short_head_finish", {15'd0, head_finish}, 16'd1);
      check("short_cmd_head",    {8'd0, cmd_head},     16'h01);
      pulse_done();
      check("short_idle_dec_en",  {15'd0, dec_en},      16'd0);
      check("short_idle_cmd_end", {15'd0, cmd_end},     16'd0);
      check("short_idle_head_fin",{15'd0, head_finish}, 16'd0);

      // ---- long command A5, len 2, 3C C3
      pulse_arm();
      pulse_delim();
      send_byte(8'hA5, 1'b1, 6'd0);
      send_byte(8'h02, 1'b1, 6'd1);
      send_byte(8'h3C, 1'b1, 6'd2);
      check("long_cmd_end_mid", {15'd0, cmd_end}, 16'd0);
      send_byte(8'hC3, 1'b1, 6'd3);
      expect_end("long");
      check("long_cmd_head", {8'd0, cmd_head}, 16'hA5);
      pulse_done();

      // ---- length overflow (17 > 16)
      pulse_arm();
      pulse_delim();
      send_byte(8'hA5, 1'b1, 6'd0);
      send_byte(8'h11, 1'b1, 6'd1);
      @(negedge dec_clk);
      check("ovf_frame_err", {15'd0, frame_err}, 16'd1);
      check("ovf_err_code",  {14'd0, err_code},  16'd2);
      check("ovf_dec_en",    {15'd0, dec_en},    16'd0);
      send_byte(8'h55, 1'b0, 6'd0);   // ignored in ERR: no strobe
      @(negedge dec_clk);
      check("ovf_frame_byte_held", {8'd0, frame_byte}, 16'h11);
      pulse_arm();
      check("ovf_cleared_err",  {15'd0, frame_err}, 16'd0);
      check("ovf_cleared_code", {14'd0, err_code},  16'd0);
      check("ovf_rearm_dec_en", {15'd0, dec_en},    16'd1);
      pulse_delim();
      send_byte(8'h04, 1'b1, 6'd0);
      expect_end("ovf_recover");
      pulse_done();

      // ---- timeout: 2 head symbols then silence
      pulse_arm();
      pulse_delim();
      send_sym(2'b10); send_sym(2'b10);
      repeat (1199) @(negedge dec_clk);
      check("tmo_before_terminal", {15'd0, frame_err}, 16'd0);
      @(negedge dec_clk);
      check("tmo_frame_err", {15'd0, frame_err}, 16'd1);
      check("tmo_err_code",  {14'd0, err_code},  16'd1);
      check("tmo_dec_en",    {15'd0, dec_en},    16'd0);

      // ---- timeout boundary: symbol on the terminal-count cycle wins
      pulse_arm();
      pulse_delim();
      send_sym(2'b10); send_sym(2'b10);
      repeat (1199) @(negedge dec_clk);
      send_sym(2'b01);
      check("tmo_edge_no_err", {15'd0, frame_err}, 16'd0);
      sb_q.push_back({8'hA4, 6'd0});
      send_sym(2'b00);
      send_byte(8'h00, 1'b1, 6'd1);   // zero length -> DONE
      expect_end("tmo_edge");
      pulse_done();

      // ---- resync after 3 payload symbols
      pulse_arm();
      pulse_delim();
      send_byte(8'hA5, 1'b1, 6'd0);
      send_byte(8'h01, 1'b1, 6'd1);
      send_sym(2'b11); send_sym(2'b00); send_sym(2'b11);
      pulse_delim();
      check("resync_byte_idx",    {10'd0, byte_idx},    16'd0);
      check("resync_head_finish", {15'd0, head_finish}, 16'd0);
      check("resync_dec_en",      {15'd0, dec_en},      16'd1);
      send_byte(8'h02, 1'b1, 6'd0);
      expect_end("resync");
      check("resync_cmd_head", {8'd0, cmd_head}, 16'h02);
      pulse_done();

      // ---- premature dec_done in PAYLOAD
      pulse_arm();
      pulse_delim();
      send_byte(8'hA5, 1'b1, 6'd0);
      send_byte(8'h05, 1'b1, 6'd1);
      send_byte(8'h3C, 1'b1, 6'd2);
      pulse_done();
      check("prem_frame_err", {15'd0, frame_err}, 16'd1);
      check("prem_err_code",  {14'd0, err_code},  16'd3);
      check("prem_cmd_end",   {15'd0, cmd_end},   16'd0);
      pulse_arm();
      check("prem_cleared", {14'd0, err_code}, 16'd0);

      // ---- reset mid-frame
      pulse_delim();
      send_byte(8'hA5, 1'b1, 6'd0);
      send_byte(8'h03, 1'b1, 6'd1);
      send_sym(2'b01); send_sym(2'b10);
      #2 rst_n = 1'b0;
      #1;
      check("rstmid_dec_en",      {15'd0, dec_en},      16'd0);
      check("rstmid_head_finish", {15'd0, head_finish}, 16'd0);
      check("rstmid_cmd_head",    {8'd0, cmd_head},     16'h00);
      check("rstmid_frame_byte",  {8'd0, frame_byte},   16'h00);
      check("rstmid_byte_idx",    {10'd0, byte_idx},    16'd0);
      @(negedge dec_clk);
      rst_n = 1'b1;
      @(negedge dec_clk);
      pulse_arm();
      pulse_delim();
      send_byte(8'h01, 1'b1, 6'd0);
      expect_end("rstmid_after");
      pulse_done();
      check("final_dec_en", {15'd0, dec_en}, 16'd0);

      @(negedge dec_clk);
      check("scoreboard_empty", sb_q.size() > 0 ? 16'd1 : 16'd0, 16'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
